// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, funct codes, control bit layout and the
// per-instruction decode table shared by the decode stage.
package decode_pkg;

  localparam int CONTROL_REG_SIZE = 8;

  localparam int CTL_REG_WE   = 0;
  localparam int CTL_I_TYPE   = 1;
  localparam int CTL_R_TYPE   = 2;
  localparam int CTL_J_TYPE   = 3;
  localparam int CTL_MEM_WE   = 4;
  localparam int CTL_MEM_WB   = 5;
  localparam int CTL_MEM_READ = 6;
  localparam int CTL_LINK     = 7;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR = 6'h08;

  typedef logic [CONTROL_REG_SIZE-1:0] ctrl_t;

  typedef struct packed {
    ctrl_t ctl;
    logic  wr_rt;
    logic  use_rs;
    logic  use_rt;
  } dec_t;

  typedef enum logic {
    RUN,
    HAZARD
  } state_t;

  function automatic dec_t decode(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    dec_t d;
    d = '0;
    d.use_rs = !(op inside {OP_J, OP_JAL, OP_LUI});
    unique case (op)
      OP_RTYPE: begin
        d.ctl[CTL_R_TYPE] = 1'b1;
        d.ctl[CTL_REG_WE] = (fn != FN_JR);
        d.use_rt = 1'b1;
      end
      OP_ADDIU, OP_SLTI, OP_ORI, OP_LUI: begin
        d.ctl[CTL_REG_WE] = 1'b1;
        d.ctl[CTL_I_TYPE] = 1'b1;
        d.wr_rt = 1'b1;
      end
      OP_LW: begin
        d.ctl[CTL_REG_WE]   = 1'b1;
        d.ctl[CTL_I_TYPE]   = 1'b1;
        d.ctl[CTL_MEM_WB]   = 1'b1;
        d.ctl[CTL_MEM_READ] = 1'b1;
        d.wr_rt = 1'b1;
      end
      OP_SW: begin
        d.ctl[CTL_I_TYPE] = 1'b1;
        d.ctl[CTL_MEM_WE] = 1'b1;
        d.use_rt = 1'b1;
      end
      OP_J: d.ctl[CTL_J_TYPE] = 1'b1;
      OP_JAL: begin
        d.ctl[CTL_J_TYPE] = 1'b1;
        d.ctl[CTL_REG_WE] = 1'b1;
        d.ctl[CTL_LINK]   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d.ctl[CTL_I_TYPE] = 1'b1;
        d.use_rt = 1'b1;
      end
      OP_BLEZ, OP_BGTZ, OP_REGIMM:
        d.ctl[CTL_I_TYPE] = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_hazard_stage_if.sv
// decode_hazard_stage_if: fetch-side inputs, downstream writer state
// and registered decode outputs of the decode stage.
interface decode_hazard_stage_if #(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW = 5,
  parameter int DATA_W = 32
);
  import decode_pkg::*;

  logic [DATA_W-1:0]            insn;
  logic                         insn_valid;
  logic [DATA_W-1:0]            pc;
  logic [NUM_STAGES*REG_AW-1:0] stage_rd;
  logic [NUM_STAGES-1:0]        stage_we;
  logic [NUM_STAGES-1:0]        stage_is_load;
  logic                         hold_in;
  logic                         flush;

  logic [DATA_W-1:0]           pcOut;
  logic [DATA_W-1:0]           irOut;
  logic [CONTROL_REG_SIZE-1:0] control;
  logic [REG_AW-1:0]           rdOut;
  logic                        valid_out;
  logic [1:0]                  fwd_sel_rs;
  logic [1:0]                  fwd_sel_rt;
  logic                        stall;
  logic [15:0]                 stall_count;

  modport master (
    output insn, insn_valid, pc,
    output stage_rd, stage_we, stage_is_load,
    output hold_in, flush,
    input  pcOut, irOut, control, rdOut, valid_out,
    input  fwd_sel_rs, fwd_sel_rt, stall, stall_count
  );

  modport slave (
    input  insn, insn_valid, pc,
    input  stage_rd, stage_we, stage_is_load,
    input  hold_in, flush,
    output pcOut, irOut, control, rdOut, valid_out,
    output fwd_sel_rs, fwd_sel_rt, stall, stall_count
  );

endinterface

// File: rtl/decode_hazard_stage_hazard_match.sv
// hazard_match: finds the nearest downstream stage writing a given
// source register; index 0 is nearest and wins.
module hazard_match #(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW = 5,
  parameter int IDX_W = 2
) (
  input  logic [REG_AW-1:0]            src_i,
  input  logic [NUM_STAGES*REG_AW-1:0] stage_rd_i,
  input  logic [NUM_STAGES-1:0]        stage_we_i,
  input  logic [NUM_STAGES-1:0]        stage_is_load_i,
  output logic                         match_o,
  output logic [IDX_W-1:0]             idx_o,
  output logic                         load_o
);

  always_comb begin
    match_o = 1'b0;
    idx_o   = '0;
    load_o  = 1'b0;
    // Walk far to near so the nearest hit overwrites the rest.
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (stage_we_i[k] &&
          stage_rd_i[k*REG_AW +: REG_AW] == src_i &&
          src_i != '0) begin
        match_o = 1'b1;
        idx_o   = IDX_W'(k);
        load_o  = stage_is_load_i[k];
      end
    end
  end

endmodule

// File: rtl/decode_hazard_stage.sv
// decode_hazard_stage: MIPS-subset decode with RAW hazard stall logic.
// Define DECODE_FWD_EN to forward from writer stages instead of stalling.
module decode_hazard_stage
  import decode_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW = 5,
  parameter int DATA_W = 32
) (
  input logic clock,
  input logic reset,
  decode_hazard_stage_if.slave bus
);

  localparam int IDX_W =
    (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic [5:0]        op;
  logic [5:0]        fn;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd_f;
  logic [REG_AW-1:0] rd_sel;
  dec_t              dec;
  logic              v;
  logic              hz;
  logic              rs_hz;
  logic              rt_hz;
  logic              rs_m;
  logic              rt_m;
  logic              rs_ld;
  logic              rt_ld;
  logic [IDX_W-1:0]  rs_idx;
  logic [IDX_W-1:0]  rt_idx;
  logic [1:0]        frs;
  logic [1:0]        frt;

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  ctrl_t             ctl_q, ctl_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              vld_q, vld_d;
  logic [1:0]        frs_q, frs_d;
  logic [1:0]        frt_q, frt_d;
  logic [15:0]       cnt_q, cnt_d;
  state_t            state_q, state_d;

  assign op   = bus.insn[31:26];
  assign fn   = bus.insn[5:0];
  assign rs   = REG_AW'(bus.insn[25:21]);
  assign rt   = REG_AW'(bus.insn[20:16]);
  assign rd_f = REG_AW'(bus.insn[15:11]);
  assign dec  = decode(op, fn);
  assign v    = bus.insn_valid & (|bus.insn);

  always_comb begin
    rd_sel = '0;
    unique case (1'b1)
      dec.ctl[CTL_R_TYPE]: rd_sel = rd_f;
      dec.wr_rt:           rd_sel = rt;
      dec.ctl[CTL_LINK]:   rd_sel = REG_AW'(31);
      default: ;
    endcase
  end

  hazard_match #(
    .NUM_STAGES(NUM_STAGES),
    .REG_AW(REG_AW),
    .IDX_W(IDX_W)
  ) u_rs_match (
    .src_i(rs),
    .stage_rd_i(bus.stage_rd),
    .stage_we_i(bus.stage_we),
    .stage_is_load_i(bus.stage_is_load),
    .match_o(rs_m),
    .idx_o(rs_idx),
    .load_o(rs_ld)
  );

  hazard_match #(
    .NUM_STAGES(NUM_STAGES),
    .REG_AW(REG_AW),
    .IDX_W(IDX_W)
  ) u_rt_match (
    .src_i(rt),
    .stage_rd_i(bus.stage_rd),
    .stage_we_i(bus.stage_we),
    .stage_is_load_i(bus.stage_is_load),
    .match_o(rt_m),
    .idx_o(rt_idx),
    .load_o(rt_ld)
  );

`ifdef DECODE_FWD_EN
  // Only a load still in the nearest stage has no data to forward.
  assign rs_hz = dec.use_rs & rs_m & (rs_idx == '0) & rs_ld;
  assign rt_hz = dec.use_rt & rt_m & (rt_idx == '0) & rt_ld;
  assign frs = (dec.use_rs & rs_m) ? 2'(rs_idx) + 2'd1 : 2'd0;
  assign frt = (dec.use_rt & rt_m) ? 2'(rt_idx) + 2'd1 : 2'd0;
`else
  logic unused_match;
  assign unused_match = ^{rs_idx, rt_idx, rs_ld, rt_ld};
  assign rs_hz = dec.use_rs & rs_m;
  assign rt_hz = dec.use_rt & rt_m;
  assign frs = 2'd0;
  assign frt = 2'd0;
`endif

  assign hz = v & ~bus.flush & (rs_hz | rt_hz);
  assign bus.stall = ~reset & (bus.hold_in | hz);

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    ctl_d   = ctl_q;
    rd_d    = rd_q;
    vld_d   = vld_q;
    frs_d   = frs_q;
    frt_d   = frt_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (!bus.hold_in) begin
      if (hz || bus.flush || !v) begin
        ir_d  = '0;
        ctl_d = '0;
        rd_d  = '0;
        vld_d = 1'b0;
        frs_d = 2'd0;
        frt_d = 2'd0;
      end else begin
        pc_d  = bus.pc;
        ir_d  = bus.insn;
        ctl_d = dec.ctl;
        rd_d  = rd_sel;
        vld_d = 1'b1;
        frs_d = frs;
        frt_d = frt;
      end
      if (hz && cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
      if (bus.flush) begin
        state_d = RUN;
      end else begin
        unique case (state_q)
          RUN:    if (hz)  state_d = HAZARD;
          HAZARD: if (!hz) state_d = RUN;
          default: state_d = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= '0;
      ir_q    <= '0;
      ctl_q   <= '0;
      rd_q    <= '0;
      vld_q   <= 1'b0;
      frs_q   <= 2'd0;
      frt_q   <= 2'd0;
      cnt_q   <= '0;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ctl_q   <= ctl_d;
      rd_q    <= rd_d;
      vld_q   <= vld_d;
      frs_q   <= frs_d;
      frt_q   <= frt_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign bus.pcOut       = pc_q;
  assign bus.irOut       = ir_q;
  assign bus.control     = ctl_q;
  assign bus.rdOut       = rd_q;
  assign bus.valid_out   = vld_q;
  assign bus.fwd_sel_rs  = frs_q;
  assign bus.fwd_sel_rt  = frt_q;
  assign bus.stall_count = cnt_q;

endmodule

// File: doc/decode_hazard_stage.md
DECODE_HAZARD_STAGE -- requirements
Module: decode_hazard_stage

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of downstream writer stages checked for hazards (index 0 = ALU, nearest).
REQ-002 Parameter REG_AW, default 5: register address width.
REQ-003 Parameter DATA_W, default 32: instruction and PC width.
REQ-004 clock  in  1: the only clock; all state updates on its rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 insn / insn_valid / pc  in  DATA_W / 1 / DATA_W: fetched instruction, its valid flag and its PC.
REQ-007 stage_rd  in  NUM_STAGES*REG_AW: destination register of each downstream stage.
REQ-008 stage_we / stage_is_load  in  NUM_STAGES each: register-write enable and load flag per stage.
REQ-009 hold_in  in  1: downstream back-pressure; freezes all output registers.
REQ-010 flush  in  1: branch-taken kill of the instruction currently in decode.
REQ-011 pcOut / irOut / control / rdOut / valid_out  out  DATA_W / DATA_W / CONTROL_REG_SIZE / REG_AW / 1: registered decode outputs.
REQ-012 fwd_sel_rs / fwd_sel_rt  out  2 each: registered forward source (0 = register file, k+1 = stage k).
REQ-013 stall  out  1: combinational; tells fetch to hold pc and insn.
REQ-014 stall_count  out  16: saturating count of hazard-stall cycles.

Function
REQ-015 Control bits (REG_WE, I_TYPE, R_TYPE, J_TYPE, MEM_WE, MEM_WB, MEM_READ, LINK) SHALL be decoded for R-type, ADDIU, SLTI, LW, SW, LUI, ORI, J, JAL, BEQ, BNE, BGTZ, BLEZ, REGIMM (BLTZ/BGEZ); JR clears REG_WE; unknown opcodes give all-zero control.
REQ-016 rdOut SHALL be rd for R-type, rt for register-writing I-type, 31 for JAL, 0 otherwise.
REQ-017 rs SHALL be a source for all instructions except J, JAL, LUI; rt SHALL be a source for R-type, SW, BEQ, BNE.
REQ-018 A source matches stage k when stage_we[k]=1, stage_rd[k]==source and source!=0; the lowest matching k wins.
REQ-019 stall SHALL be asserted when insn_valid=1, flush=0 and a hazard exists per REQ-029/030, or when hold_in=1.
REQ-020 Latency: one cycle from insn to registered outputs when stall=0 and hold_in=0.
REQ-021 Hazard stall (hold_in=0): next cycle outputs a bubble (irOut=0, control=0, rdOut=0, valid_out=0, fwd_sel=0), pcOut unchanged.
REQ-022 hold_in=1: every output register holds its value; hold_in has priority over hazard and flush.
REQ-023 flush=1 with hold_in=0: next cycle outputs a bubble regardless of hazards; stall=0 in that cycle.
REQ-024 insn_valid=0 or insn=0: bubble output, no hazard check, stall=0 unless hold_in.
REQ-025 FSM states RUN and HAZARD: RUN->HAZARD when a hazard stall is issued; HAZARD->RUN in the first cycle with no hazard; flush forces RUN; state is observable only via stall_count behaviour.
REQ-026 stall_count SHALL increment once per cycle in which a hazard stall (not hold_in) is issued, saturating at 16'hFFFF.

Reset
REQ-027 reset=1 SHALL clear pcOut, irOut, control, rdOut, fwd_sel_rs, fwd_sel_rt, valid_out, stall_count to 0 and FSM to RUN on the next edge, overriding hold_in and flush, including mid-stall.
REQ-028 stall SHALL be 0 while reset=1.

Configuration
REQ-029 With DECODE_FWD_EN defined: matches produce fwd_sel = k+1 without stalling, except a match at stage 0 with stage_is_load[0]=1, which stalls one cycle.
REQ-030 Without DECODE_FWD_EN: any match at any stage stalls; fwd_sel outputs are constant 0.

Structure
REQ-031 Opcodes, funct codes, control bit indices and CONTROL_REG_SIZE SHALL live in shared package decode_pkg.
REQ-032 One sub-module hazard_match SHALL compare one source against all stages and return match flag, winning index and load flag; instantiated twice (rs, rt).

Verification
REQ-033 ADDIU r2 in stage 0 (we=1), decode ADDU r3,r2,r1: with DECODE_FWD_EN -> stall=0, fwd_sel_rs=1; without -> stall=1, bubble, stall_count=1.
REQ-034 LW r4 in stage 0 (is_load=1), decode SW r4 -> stall for exactly one cycle with DECODE_FWD_EN, then fwd_sel_rt=2 after load moves to stage 1.
REQ-035 Stage 0 and stage 2 both write r5, decode uses r5 with DECODE_FWD_EN -> fwd_sel_rs=1 (nearest wins).
REQ-036 Source r0 with stage_rd=0, we=1 -> no stall, fwd_sel=0.
REQ-037 hold_in=1 for 3 cycles during hazard -> outputs frozen, stall_count unchanged; flush together with hazard -> bubble, stall=0.
REQ-038 reset asserted mid-HAZARD with stall_count=7 -> all outputs 0 next edge, stall_count=0; force 65536 stalls -> stall_count stays 16'hFFFF.
